ar_id_remap_stage: RTL and testbench
====================================

// Module: ar_id_remap_stage
// PURPOSE
//  Sits upstream of the ID allocator and wraps it onto the AXI read path.
//  AR path: buffers one master AR, requests a unique ID, forwards the AR downstream with the remapped ID.
//  R path: restores the original ID on every returning beat; frees the unique ID on the RLAST beat.
//  One outstanding AR in the stage; R path is a one-deep registered pipeline stage.
// PARAMETERS
//  ID_WIDTH      16  original and unique ID width; unique ID is zero-padded to this width
//  ADDR_WIDTH    32  ARADDR width
//  LEN_WIDTH     8   ARLEN width
//  DATA_WIDTH    64  RDATA width
//  STALL_CNT_W   16  alloc-stall counter width (used only with ALLOC_STALL_CNT_EN)
// PORTS
//  clk                 in   1           single clock
//  rst_n               in   1           asynchronous, active-low reset
//  ar_valid_in         in   1           master AR valid
//  ar_ready_out        out  1           master AR ready
//  ar_id_in            in   ID_WIDTH    master original ARID
//  ar_addr_in          in   ADDR_WIDTH  master ARADDR
//  ar_len_in           in   LEN_WIDTH   master ARLEN
//  alloc_req           out  1           to allocator
//  in_orig_id          out  ID_WIDTH    to allocator: held original ID
//  alloc_gnt           in   1           from allocator, same-cycle (combinational) grant
//  unique_id           in   ID_WIDTH    from allocator: granted unique ID
//  id_matrix_full      in   1           from allocator
//  ar_valid_out        out  1           slave AR valid
//  ar_ready_in         in   1           slave AR ready
//  ar_id_out           out  ID_WIDTH    remapped ARID
//  ar_addr_out         out  ADDR_WIDTH  ARADDR passthrough
//  ar_len_out          out  LEN_WIDTH   ARLEN passthrough
//  r_valid_in          in   1           slave R valid
//  r_ready_out         out  1           slave R ready
//  r_id_in             in   ID_WIDTH    unique RID
//  r_data_in           in   DATA_WIDTH  slave RDATA
//  r_resp_in           in   2           slave RRESP
//  r_last_in           in   1           slave RLAST
//  free_req            out  1           to allocator: free on RLAST handshake
//  unique_id_to_free   out  ID_WIDTH    to allocator: equals r_id_in at all times
//  restored_id         in   ID_WIDTH    from allocator: combinational lookup of unique_id_to_free
//  r_valid_out         out  1           master R valid
//  r_ready_in          in   1           master R ready
//  r_id_out            out  ID_WIDTH    restored original RID
//  r_data_out          out  DATA_WIDTH  RDATA
//  r_resp_out          out  2           RRESP
//  r_last_out          out  1           RLAST
// BEHAVIOUR
//  - Reset: FSM=A_EMPTY; ar_valid_out, r_valid_out, alloc_req, free_req = 0; all data/ID output registers = 0.
//  - A valid/ready channel never has valid depend on ready; a beat transfers when valid & ready = 1 at posedge.
//  - AR FSM:
//    - A_EMPTY: ar_ready_out=1. On handshake, capture id/addr/len -> A_ALLOC.
//    - A_ALLOC: ar_ready_out=0, alloc_req=1, in_orig_id = captured ID.
//      - alloc_gnt=1: register unique_id into ar_id_out -> A_ISSUE.
//      - alloc_gnt=0 (full or no row): hold alloc_req; stay.
//    - A_ISSUE: ar_valid_out=1, outputs stable. On ar_ready_in -> A_EMPTY.
//    - alloc_req is 0 outside A_ALLOC, so the allocator sees exactly one granted request per AR.
//  - AR latency: handshake at cycle t; with immediate grant, ar_valid_out=1 from t+2. Peak throughput is 1 AR per 3 cycles.
//  - R stage:
//    - r_ready_out = ~r_valid_out | r_ready_in.
//    - On an R handshake: register restored_id, data, resp and last into the outputs; r_valid_out=1 next cycle.
//    - Otherwise r_valid_out clears when r_ready_in=1, and holds when r_ready_in=0.
//  - free_req = r_valid_in & r_ready_out & r_last_in (combinational, exactly one cycle per burst).
//    - restored_id is sampled the same cycle, before the allocator updates.
//  - Simultaneous alloc (A_ALLOC grant) and free in one cycle: both are driven; the allocator resolves them.
//  - Reset mid-operation: the captured AR and the R beat in flight are dropped; no free_req is issued; outputs return to reset values immediately.
// CONFIGURATION
//  - ALLOC_STALL_CNT_EN defined:
//    - Adds output port alloc_stall_cnt [STALL_CNT_W-1:0], reset 0.
//    - Increments by 1 per cycle in A_ALLOC with alloc_gnt=0; saturates at all-ones; never clears except on reset.
//  - ALLOC_STALL_CNT_EN undefined: the port and counter do not exist; all other behaviour is identical.
// TESTING
//  - Reset, idle: ar_ready_out=1, ar_valid_out=0, r_valid_out=0, free_req=0, alloc_req=0.
//  - AR id=0x00A5, addr=0x1000, len=3, immediate grant of unique 0x0012 -> ar_valid_out at t+2; ar_id_out=0x0012; addr/len unchanged.
//  - Grant withheld 5 cycles (id_matrix_full=1) -> alloc_req held 5+ cycles; ar_ready_out=0; stall counter=5 with macro.
//  - R burst of 4 beats, r_id_in=0x0012, restored_id=0x00A5 -> 4 beats out with r_id_out=0x00A5; free_req pulses only on beat 4.
//  - r_ready_in=0 for 3 cycles mid-burst -> r_valid_out held; r_ready_out=0; no beat lost or duplicated; data order preserved.
//  - rst_n asserted while in A_ISSUE -> ar_valid_out=0 immediately; FSM=A_EMPTY after release.

Source files
------------

// File: rtl/ar_id_remap_stage_if.sv
// Bus bundle for ar_id_remap_stage: master AR, allocator handshake,
// slave AR, slave R, allocator free/lookup and master R signals.
// The slave modport is the stage's own view; master is the environment's.
// ALLOC_STALL_CNT_EN adds the alloc_stall_cnt observation signal.
interface ar_id_remap_stage_if #(
   parameter int ID_WIDTH    = 16,
   parameter int ADDR_WIDTH  = 32,
   parameter int LEN_WIDTH   = 8,
   parameter int DATA_WIDTH  = 64,
   parameter int STALL_CNT_W = 16
);
   // master AR
   logic                  ar_valid_in;
   logic                  ar_ready_out;
   logic [ID_WIDTH-1:0]   ar_id_in;
   logic [ADDR_WIDTH-1:0] ar_addr_in;
   logic [LEN_WIDTH-1:0]  ar_len_in;
   // allocator request
   logic                  alloc_req;
   logic [ID_WIDTH-1:0]   in_orig_id;
   logic                  alloc_gnt;
   logic [ID_WIDTH-1:0]   unique_id;
   logic                  id_matrix_full;
   // slave AR
   logic                  ar_valid_out;
   logic                  ar_ready_in;
   logic [ID_WIDTH-1:0]   ar_id_out;
   logic [ADDR_WIDTH-1:0] ar_addr_out;
   logic [LEN_WIDTH-1:0]  ar_len_out;
   // slave R
   logic                  r_valid_in;
   logic                  r_ready_out;
   logic [ID_WIDTH-1:0]   r_id_in;
   logic [DATA_WIDTH-1:0] r_data_in;
   logic [1:0]            r_resp_in;
   logic                  r_last_in;
   // allocator free / lookup
   logic                  free_req;
   logic [ID_WIDTH-1:0]   unique_id_to_free;
   logic [ID_WIDTH-1:0]   restored_id;
   // master R
   logic                  r_valid_out;
   logic                  r_ready_in;
   logic [ID_WIDTH-1:0]   r_id_out;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic [1:0]            r_resp_out;
   logic                  r_last_out;
`ifdef ALLOC_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] alloc_stall_cnt;
`endif

   modport slave (
      input  ar_valid_in, ar_id_in, ar_addr_in, ar_len_in,
             alloc_gnt, unique_id, id_matrix_full,
             ar_ready_in,
             r_valid_in, r_id_in, r_data_in, r_resp_in, r_last_in,
             restored_id, r_ready_in,
      output
`ifdef ALLOC_STALL_CNT_EN
             alloc_stall_cnt,
`endif
             ar_ready_out, alloc_req, in_orig_id,
             ar_valid_out, ar_id_out, ar_addr_out, ar_len_out,
             r_ready_out, free_req, unique_id_to_free,
             r_valid_out, r_id_out, r_data_out, r_resp_out, r_last_out
   );

   modport master (
      output ar_valid_in, ar_id_in, ar_addr_in, ar_len_in,
             alloc_gnt, unique_id, id_matrix_full,
             ar_ready_in,
             r_valid_in, r_id_in, r_data_in, r_resp_in, r_last_in,
             restored_id, r_ready_in,
      input
`ifdef ALLOC_STALL_CNT_EN
             alloc_stall_cnt,
`endif
             ar_ready_out, alloc_req, in_orig_id,
             ar_valid_out, ar_id_out, ar_addr_out, ar_len_out,
             r_ready_out, free_req, unique_id_to_free,
             r_valid_out, r_id_out, r_data_out, r_resp_out, r_last_out
   );
endinterface

// File: rtl/ar_id_remap_stage.sv
// AXI read-path wrapper around the ID allocator.
// AR path: holds one master AR, obtains a unique ID, issues it downstream.
// R path: one-deep registered stage restoring the original ID per beat and
// freeing the unique ID on the RLAST handshake.
// Optional: define ALLOC_STALL_CNT_EN to add the saturating alloc_stall_cnt.
module ar_id_remap_stage #(
   parameter int ID_WIDTH    = 16,
   parameter int ADDR_WIDTH  = 32,
   parameter int LEN_WIDTH   = 8,
   parameter int DATA_WIDTH  = 64,
   parameter int STALL_CNT_W = 16
) (
   input logic                clk,
   input logic                rst_n,
   ar_id_remap_stage_if.slave bus
);

   typedef enum logic [1:0] {
      A_EMPTY = 2'd0,
      A_ALLOC = 2'd1,
      A_ISSUE = 2'd2
   } a_state_t;

   a_state_t a_state;
   logic     ar_hs;
   logic     r_in_hs;
   logic     unused_full;

   // The full flag is informational; alloc_gnt alone decides progress.
   assign unused_full = bus.id_matrix_full;

   assign ar_hs   = bus.ar_valid_in & bus.ar_ready_out;
   assign r_in_hs = bus.r_valid_in & bus.r_ready_out;

   // R stage accepts when empty or when its held beat leaves this cycle.
   assign bus.r_ready_out       = ~bus.r_valid_out | bus.r_ready_in;
   assign bus.unique_id_to_free = bus.r_id_in;
   // Reset gates the free so a beat arriving during reset never frees an ID.
   assign bus.free_req          = rst_n & r_in_hs & bus.r_last_in;

   // AR FSM with registered handshake/request outputs and held AR fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
         a_state          <= A_EMPTY;
         bus.ar_ready_out <= 1'b1;
         bus.alloc_req    <= 1'b0;
         bus.ar_valid_out <= 1'b0;
         bus.in_orig_id   <= '0;
         bus.ar_id_out    <= '0;
         bus.ar_addr_out  <= '0;
         bus.ar_len_out   <= '0;
      end else begin
         case (a_state)
            A_EMPTY: begin
               if (ar_hs) begin
                  bus.in_orig_id   <= bus.ar_id_in;
                  bus.ar_addr_out  <= bus.ar_addr_in;
                  bus.ar_len_out   <= bus.ar_len_in;
                  bus.ar_ready_out <= 1'b0;
                  bus.alloc_req    <= 1'b1;
                  a_state          <= A_ALLOC;
               end
            end
            A_ALLOC: begin
               if (bus.alloc_gnt) begin
                  bus.ar_id_out    <= bus.unique_id;
                  bus.alloc_req    <= 1'b0;
                  bus.ar_valid_out <= 1'b1;
                  a_state          <= A_ISSUE;
               end
            end
            A_ISSUE: begin
               if (bus.ar_ready_in) begin
                  bus.ar_valid_out <= 1'b0;
                  bus.ar_ready_out <= 1'b1;
                  a_state          <= A_EMPTY;
               end
            end
            default: begin
               bus.ar_ready_out <= 1'b1;
               bus.alloc_req    <= 1'b0;
               bus.ar_valid_out <= 1'b0;
               a_state          <= A_EMPTY;
            end
         endcase
      end
   end

   // R pipeline register: load on accept, drain when the master takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.r_valid_out <= 1'b0;
         bus.r_id_out    <= '0;
         bus.r_data_out  <= '0;
         bus.r_resp_out  <= '0;
         bus.r_last_out  <= 1'b0;
      end else if (r_in_hs) begin
         bus.r_valid_out <= 1'b1;
         bus.r_id_out    <= bus.restored_id;
         bus.r_data_out  <= bus.r_data_in;
         bus.r_resp_out  <= bus.r_resp_in;
         bus.r_last_out  <= bus.r_last_in;
      end else if (bus.r_ready_in) begin
         bus.r_valid_out <= 1'b0;
      end
   end

`ifdef ALLOC_STALL_CNT_EN
   // Count cycles spent waiting for a grant; sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.alloc_stall_cnt <= '0;
      end else if (a_state == A_ALLOC && !bus.alloc_gnt && bus.alloc_stall_cnt != '1) begin
         bus.alloc_stall_cnt <= bus.alloc_stall_cnt + 1'b1;
      end
   end
`else
   // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_ar_id_remap_stage.sv
// Bench for ar_id_remap_stage: directed scenarios followed by random traffic,
// all checked against a transaction-level model (held AR + R beat queue).
// Honours ALLOC_STALL_CNT_EN when defined.
module tb_ar_id_remap_stage;

   localparam int IDW = 16;
   localparam int AW  = 32;
   localparam int LW  = 8;
   localparam int DW  = 64;
   localparam int SW  = 16;

   typedef struct {
      logic [IDW-1:0] id;
      logic [DW-1:0]  data;
      logic [1:0]     resp;
      logic           last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   ar_id_remap_stage_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                          .DATA_WIDTH(DW), .STALL_CNT_W(SW)) bus ();

   ar_id_remap_stage #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                       .DATA_WIDTH(DW), .STALL_CNT_W(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Allocator lookup table: unique ID (low byte) -> original ID.
   logic [IDW-1:0] id_map [256];
   assign bus.restored_id = id_map[bus.unique_id_to_free[7:0]];

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit             m_held;
   bit             m_granted;
   logic [IDW-1:0] m_id;
   logic [IDW-1:0] m_uid;
   logic [AW-1:0]  m_addr;
   logic [LW-1:0]  m_len;
   logic [SW-1:0]  m_stall;
   beat_t          r_q [$];
   int             r_in_cnt   = 0;
   int             r_out_cnt  = 0;
   int             free_seen  = 0;
   int             free_exp   = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.ar_valid_in    = 1'b0;
      bus.ar_id_in       = '0;
      bus.ar_addr_in     = '0;
      bus.ar_len_in      = '0;
      bus.alloc_gnt      = 1'b0;
      bus.unique_id      = '0;
      bus.id_matrix_full = 1'b0;
      bus.ar_ready_in    = 1'b0;
      bus.r_valid_in     = 1'b0;
      bus.r_id_in        = '0;
      bus.r_data_in      = '0;
      bus.r_resp_in      = '0;
      bus.r_last_in      = 1'b0;
      bus.r_ready_in     = 1'b0;
   endtask

   task automatic clear_model();
      m_held    = 1'b0;
      m_granted = 1'b0;
      m_stall   = '0;
      r_q.delete();
   endtask

   // Called just after a negedge with inputs set; checks outputs, advances
   // the model, and returns after the following negedge.
   task automatic step(output bit r_acc);
      bit    e_ardy, e_alloc, e_avo, e_rvo, e_rro, r_hs;
      beat_t b;
      #1;
      e_ardy  = !m_held;
      e_alloc = m_held && !m_granted;
      e_avo   = m_held && m_granted;
      e_rvo   = (r_q.size() != 0);
      e_rro   = !e_rvo || bus.r_ready_in;
      r_hs    = bus.r_valid_in && e_rro;

      check("ar_ready_out", 64'(bus.ar_ready_out), 64'(e_ardy));
      check("alloc_req", 64'(bus.alloc_req), 64'(e_alloc));
      if (e_alloc) check("in_orig_id", 64'(bus.in_orig_id), 64'(m_id));
      check("ar_valid_out", 64'(bus.ar_valid_out), 64'(e_avo));
      if (e_avo) begin
         check("ar_id_out", 64'(bus.ar_id_out), 64'(m_uid));
         check("ar_addr_out", 64'(bus.ar_addr_out), 64'(m_addr));
         check("ar_len_out", 64'(bus.ar_len_out), 64'(m_len));
      end
      check("r_valid_out", 64'(bus.r_valid_out), 64'(e_rvo));
      if (e_rvo) begin
         b = r_q[0];
         check("r_id_out", 64'(bus.r_id_out), 64'(b.id));
         check("r_data_out", bus.r_data_out, b.data);
         check("r_resp_out", 64'(bus.r_resp_out), 64'(b.resp));
         check("r_last_out", 64'(bus.r_last_out), 64'(b.last));
      end
      check("r_ready_out", 64'(bus.r_ready_out), 64'(e_rro));
      check("free_req", 64'(bus.free_req), 64'(r_hs && bus.r_last_in));
      check("id_to_free", 64'(bus.unique_id_to_free), 64'(bus.r_id_in));
`ifdef ALLOC_STALL_CNT_EN
      check("stall_cnt", 64'(bus.alloc_stall_cnt), 64'(m_stall));
`endif
      if (bus.free_req) free_seen++;
      if (r_hs && bus.r_last_in) free_exp++;

      if (e_avo && bus.ar_ready_in) begin
         m_held = 1'b0;
      end else if (e_alloc && bus.alloc_gnt) begin
         m_granted = 1'b1;
         m_uid     = bus.unique_id;
      end else if (e_alloc && m_stall != '1) begin
         m_stall = m_stall + 1'b1;
      end
      if (e_ardy && bus.ar_valid_in) begin
         m_held    = 1'b1;
         m_granted = 1'b0;
         m_id      = bus.ar_id_in;
         m_addr    = bus.ar_addr_in;
         m_len     = bus.ar_len_in;
      end
      if (e_rvo && bus.r_ready_in) begin
         void'(r_q.pop_front());
         r_out_cnt++;
      end
      if (r_hs) begin
         b.id   = id_map[bus.r_id_in[7:0]];
         b.data = bus.r_data_in;
         b.resp = bus.r_resp_in;
         b.last = bus.r_last_in;
         r_q.push_back(b);
         r_in_cnt++;
      end
      r_acc = r_hs;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ar_ready"}, 64'(bus.ar_ready_out), 64'(1'b1));
      check({tag, "_ar_valid"}, 64'(bus.ar_valid_out), 64'(1'b0));
      check({tag, "_alloc_req"}, 64'(bus.alloc_req), 64'(1'b0));
      check({tag, "_r_valid"}, 64'(bus.r_valid_out), 64'(1'b0));
      check({tag, "_free_req"}, 64'(bus.free_req), 64'(1'b0));
      check({tag, "_ar_id"}, 64'(bus.ar_id_out), 64'(0));
      check({tag, "_r_id"}, 64'(bus.r_id_out), 64'(0));
`ifdef ALLOC_STALL_CNT_EN
      check({tag, "_stall"}, 64'(bus.alloc_stall_cnt), 64'(0));
`endif
   endtask

   initial begin
      bit acc;
      int i;
      int base_out;
      int base_free;

      for (int k = 0; k < 256; k++) id_map[k] = 16'($urandom);
      idle_inputs();
      clear_model();

      // Reset / idle
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1 check_reset_values("rst");
      rst_n = 1'b1;
      @(negedge clk);
      step(acc);

      // Single AR with immediate grant
      bus.ar_valid_in = 1'b1;
      bus.ar_id_in    = 16'h00A5;
      bus.ar_addr_in  = 32'h0000_1000;
      bus.ar_len_in   = 8'd3;
      bus.alloc_gnt   = 1'b1;
      bus.unique_id   = 16'h0012;
      step(acc);                       // handshake
      bus.ar_valid_in = 1'b0;
      #1 check("lat_t1_valid", 64'(bus.ar_valid_out), 64'(1'b0));
      step(acc);                       // grant
      #1 check("lat_t2_valid", 64'(bus.ar_valid_out), 64'(1'b1));
      check("lat_t2_id", 64'(bus.ar_id_out), 64'(16'h0012));
      step(acc);
      bus.ar_ready_in = 1'b1;
      step(acc);                       // issued
      bus.ar_ready_in = 1'b0;

      // Grant withheld for five cycles
      bus.ar_valid_in = 1'b1;
      bus.ar_id_in    = 16'h0033;
      bus.ar_addr_in  = 32'h0000_2040;
      bus.ar_len_in   = 8'd7;
      bus.alloc_gnt   = 1'b0;
      step(acc);
      bus.ar_valid_in    = 1'b0;
      bus.id_matrix_full = 1'b1;
      repeat (5) step(acc);
      #1 check("stall_alloc_held", 64'(bus.alloc_req), 64'(1'b1));
      check("stall_ar_ready", 64'(bus.ar_ready_out), 64'(1'b0));
`ifdef ALLOC_STALL_CNT_EN
      check("stall_cnt_5", 64'(bus.alloc_stall_cnt), 64'(5));
`endif
      bus.id_matrix_full = 1'b0;
      bus.alloc_gnt      = 1'b1;
      bus.unique_id      = 16'h0007;
      step(acc);
      bus.alloc_gnt   = 1'b0;
      bus.ar_ready_in = 1'b1;
      step(acc);
      bus.ar_ready_in = 1'b0;

      // Four-beat R burst with restored ID
      id_map[8'h12]  = 16'h00A5;
      base_out       = r_out_cnt;
      base_free      = free_seen;
      bus.r_ready_in = 1'b1;
      for (int b = 0; b < 4; b++) begin
         bus.r_valid_in = 1'b1;
         bus.r_id_in    = 16'h0012;
         bus.r_data_in  = 64'hD000_0000_0000_0000 | 64'(b);
         bus.r_resp_in  = 2'b00;
         bus.r_last_in  = (b == 3);
         step(acc);
      end
      bus.r_valid_in = 1'b0;
      bus.r_last_in  = 1'b0;
      step(acc);
      check("burst_beats", 64'(r_out_cnt - base_out), 64'(4));
      check("burst_frees", 64'(free_seen - base_free), 64'(1));

      // Six-beat burst with master back-pressure for three cycles
      base_out = r_out_cnt;
      i = 0;
      for (int c = 0; c < 50 && i < 6; c++) begin
         bus.r_valid_in = 1'b1;
         bus.r_id_in    = 16'h0012;
         bus.r_data_in  = 64'hB0B0_0000_0000_0000 | 64'(i);
         bus.r_resp_in  = 2'(i);
         bus.r_last_in  = (i == 5);
         bus.r_ready_in = !(c >= 2 && c < 5);
         step(acc);
         if (acc) i++;
      end
      check("bp_accepted", 64'(i), 64'(6));
      bus.r_valid_in = 1'b0;
      bus.r_last_in  = 1'b0;
      bus.r_ready_in = 1'b1;
      repeat (2) step(acc);
      check("bp_beats", 64'(r_out_cnt - base_out), 64'(6));

      // Reset while an AR is issuing and an R beat is held
      bus.ar_valid_in = 1'b1;
      bus.ar_id_in    = 16'h0044;
      bus.alloc_gnt   = 1'b1;
      bus.unique_id   = 16'h0009;
      bus.ar_ready_in = 1'b0;
      step(acc);
      bus.ar_valid_in = 1'b0;
      bus.r_valid_in  = 1'b1;
      bus.r_id_in     = 16'h0012;
      bus.r_last_in   = 1'b0;
      bus.r_ready_in  = 1'b0;
      step(acc);
      bus.r_valid_in = 1'b0;
      step(acc);
      #1 check("pre_rst_issue", 64'(bus.ar_valid_out), 64'(1'b1));
      rst_n = 1'b0;
      #1 check_reset_values("mid_rst");
      r_in_cnt = r_in_cnt - r_q.size();
      clear_model();
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      step(acc);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         bus.ar_valid_in    = 1'($urandom_range(0, 1));
         bus.ar_id_in       = 16'($urandom);
         bus.ar_addr_in     = 32'($urandom);
         bus.ar_len_in      = 8'($urandom);
         bus.alloc_gnt      = ($urandom_range(0, 3) != 0);
         bus.id_matrix_full = !bus.alloc_gnt;
         bus.unique_id      = 16'($urandom_range(0, 255));
         bus.ar_ready_in    = 1'($urandom_range(0, 1));
         bus.r_valid_in     = 1'($urandom_range(0, 1));
         bus.r_id_in        = 16'($urandom_range(0, 255));
         bus.r_data_in      = {32'($urandom), 32'($urandom)};
         bus.r_resp_in      = 2'($urandom);
         bus.r_last_in      = ($urandom_range(0, 3) == 0);
         bus.r_ready_in     = ($urandom_range(0, 3) != 0);
         step(acc);
      end
      idle_inputs();
      bus.r_ready_in = 1'b1;
      repeat (2) step(acc);
      check("final_r_count", 64'(r_out_cnt), 64'(r_in_cnt));
      check("final_free_count", 64'(free_seen), 64'(free_exp));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
